shift_add_mult_32b: RTL

Sequential 32x32 unsigned multiplier producing a 64-bit product by shift-and-add, one multiplier bit per clock. It sits directly downstream of the 32-bit ripple adder, fulladder_32b. It feeds that adder the running partial product and the multiplicand, then consumes its sum and carry every iteration. It is the first multi-cycle arithmetic unit in the ALU path, with a start/busy/done handshake toward the control unit.

---
 rtl/mult_pkg.sv | 13 +
 rtl/shift_add_mult_32b_if.sv | 15 +
 rtl/fulladder_32b.sv | 21 ++
 rtl/shift_add_mult_32b.sv | 98 +++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the shift-and-add multiplier.
package mult_pkg;

   localparam int MULT_W    = 32;
   localparam int MULT_ITER = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mult_state_t;

endpackage

// File: rtl/shift_add_mult_32b_if.sv
// Start/busy/done handshake plus operand and result bus of the multiplier.
interface shift_add_mult_32b_if;
   import mult_pkg::*;

   logic                  start;
   logic [MULT_W-1:0]     a;
   logic [MULT_W-1:0]     b;
   logic                  busy;
   logic                  done;
   logic [2*MULT_W-1:0]   product;
   logic                  hi_nz;

   modport master (output start, a, b, input busy, done, product, hi_nz);
   modport slave  (input start, a, b, output busy, done, product, hi_nz);
endinterface

// File: rtl/fulladder_32b.sv
// 32-bit ripple-carry adder; upstream arithmetic block reused by the multiplier.
module fulladder_32b (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cin,
   output logic [31:0] sum,
   output logic        cout
);

   logic [32:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < 32; i++) begin : g_fa
      assign sum[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign cout = c[32];

endmodule

// File: rtl/shift_add_mult_32b.sv
// Sequential 32x32 unsigned shift-and-add multiplier, one multiplier bit per clock.
// Optional macro EARLY_TERM_EN: zero operands finish in one cycle without iterating.
//
// state | meaning
// IDLE  | waiting for start, product held
// RUN   | one add/shift iteration per clock, busy=1
// DONE  | one-cycle done pulse; start here chains the next operation
module shift_add_mult_32b
   import mult_pkg::*;
#(
   parameter int WIDTH = MULT_W,
   parameter int CNT_W = 6
) (
   input  logic               clk,
   input  logic               rst_n,
   shift_add_mult_32b_if.slave mif
);

   mult_state_t            state;
   logic [WIDTH-1:0]       m_q;
   logic [2*WIDTH-1:0]     p_q;
   logic [CNT_W-1:0]       cnt;
   logic                   busy_q;
   logic                   done_q;
   logic [WIDTH-1:0]       sum;
   logic                   carry;
   logic                   zero_op;

   fulladder_32b u_add (
      .a    (p_q[2*WIDTH-1:WIDTH]),
      .b    (m_q),
      .cin  (1'b0),
      .sum  (sum),
      .cout (carry)
   );

`ifdef EARLY_TERM_EN
   assign zero_op = (mif.a == '0) || (mif.b == '0);
`else
   assign zero_op = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         m_q    <= '0;
         p_q    <= '0;
         cnt    <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               state  <= IDLE;
               busy_q <= 1'b0;
               done_q <= 1'b0;
               if (mif.start && zero_op) begin
                  m_q    <= mif.a;
                  p_q    <= '0;
                  cnt    <= '0;
                  state  <= DONE;
                  done_q <= 1'b1;
               end else if (mif.start) begin
                  m_q    <= mif.a;
                  p_q    <= {{WIDTH{1'b0}}, mif.b};
                  cnt    <= '0;
                  state  <= RUN;
                  busy_q <= 1'b1;
               end
            end
            RUN: begin
               // carry-out lands in the top bit so no partial sum is ever lost
               if (p_q[0])
                  p_q <= {carry, sum, p_q[WIDTH-1:1]};
               else
                  p_q <= {1'b0, p_q[2*WIDTH-1:1]};
               cnt <= cnt + 1'b1;
               if (cnt == CNT_W'(MULT_ITER - 1)) begin
                  state  <= DONE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
               end
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
               done_q <= 1'b0;
            end
         endcase
      end
   end

   assign mif.busy    = busy_q;
   assign mif.done    = done_q;
   assign mif.product = p_q;
   assign mif.hi_nz   = |p_q[2*WIDTH-1:WIDTH];

endmodule
